booth_issue_ctrl: RTL
=====================

BOOTH_ISSUE_CTRL -- requirements
Module: booth_issue_ctrl

Interface
REQ-001 Parameter: WDOG_LIMIT, default 20, maximum cycles to wait for mul_done after a start pulse.
REQ-002 Parameter: FIFO_DEPTH, default 2, result buffer entries.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_a  input  8  multiplier operand, signed two's complement.
REQ-007 in_b  input  8  multiplicand operand, signed two's complement.
REQ-008 in_ready  output  1  operand pair accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-009 mul_start  output  1  one-cycle start pulse to the Booth multiplier.
REQ-010 mul_a  output  8  latched multiplier operand, stable from ISSUE until return to IDLE.
REQ-011 mul_b  output  8  latched multiplicand operand, same stability rule.
REQ-012 mul_done  input  1  multiplier idle flag (high when not busy).
REQ-013 mul_product  input  16  multiplier result, valid while mul_done=1 after completion.
REQ-014 out_valid  output  1  result buffer non-empty.
REQ-015 out_product  output  16  head-of-buffer product.
REQ-016 out_ready  input  1  consumer pops the head on out_valid and out_ready.
REQ-017 err  output  1  sticky watchdog timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_DONE.
REQ-019 IDLE: in_ready=1 iff buffer count < FIFO_DEPTH; on accept, latch in_a/in_b and go to ISSUE.
REQ-020 ISSUE: mul_start=1 for exactly one cycle; next state WAIT_LOW.
REQ-021 WAIT_LOW: stay until mul_done=0, then WAIT_DONE.
REQ-022 WAIT_DONE: on mul_done=1, push mul_product into buffer and return to IDLE in the same edge.
REQ-023 in_ready SHALL be 0 in every state other than IDLE; at most one operation in flight.
REQ-024 Overflow cannot occur: accept is gated on count < FIFO_DEPTH, so a push always finds a free slot.
REQ-025 Pop on out_valid & out_ready; simultaneous push and pop leaves count unchanged, and ordering is FIFO.
REQ-026 Pop when empty is ignored; out_product is don't-care when out_valid=0.
REQ-027 Watchdog: cycle counter clears on entering WAIT_LOW and increments in WAIT_LOW and WAIT_DONE.
REQ-028 Watchdog: when the counter reaches WAIT_LIMIT... (read: WDOG_LIMIT), set err=1, return to IDLE, and push nothing.
REQ-029 err is sticky and SHALL clear only on reset.
REQ-030 Buffer pointers wrap modulo FIFO_DEPTH.
REQ-031 Latency: accept at edge E0; mul_start high during cycle E0..E1; with a multiplier whose done rises 9 edges after start sampling, out_valid rises after edge E11.

Reset
REQ-032 On reset=0 at a clock edge: state=IDLE, count=0, pointers=0, err=0, mul_start=0, mul_a=mul_b=0, watchdog=0.
REQ-033 Reset overrides all activity, including mid-operation and mid-pop; buffered results are discarded.
REQ-034 After reset release, in_ready=1 in the first cycle.

Structure
REQ-035 Shared package booth_pkg SHALL hold the FSM state typedef, WDOG_LIMIT default, and FIFO_DEPTH default.
REQ-036 Result buffer SHALL be a sub-module booth_result_fifo (push, pop, count, head data, synchronous active-low reset).
REQ-037 Instantiation of the multiplier is outside this block; the connection is by ports only.

Verification
REQ-038 Single op, Booth datapath attached: in_a=0x03, in_b=0x05 -> one mul_start pulse; out_product=0x000F with out_valid held until out_ready.
REQ-039 Signed op: in_a=0xFE, in_b=0x03 -> out_product=0xFFFA; in_a=0x80, in_b=0x80 -> 0x4000.
REQ-040 Backpressure: out_ready=0, offer 3 ops -> two results buffered, in_ready=0 afterwards, third op not accepted until one pop occurs; results come out in order.
REQ-041 Simultaneous push and pop with count=1 -> count stays 1, and the next head is the newer result.
REQ-042 Watchdog: mul_done model held low after start -> err=1 after 20 cycles, FSM in IDLE, no push, in_ready=1.
REQ-043 Reset mid-op: reset=0 during WAIT_DONE with count=1 -> next cycle out_valid=0, err=0, in_ready=1, no stale push.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the Booth multiplier issue controller.
//   state_t          : controller FSM state encoding
//   WDOG_LIMIT_DEF   : default watchdog limit (cycles waiting on mul_done)
//   FIFO_DEPTH_DEF   : default result buffer depth
//   cnt_width()      : bits needed to hold values 0..n
//   ptr_width()      : bits needed to index n entries (at least 1)
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int WDOG_LIMIT_DEF = 20;
  localparam int FIFO_DEPTH_DEF = 2;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/booth_result_fifo.sv
// booth_result_fifo: small result buffer between the issue FSM and the consumer.
//   clk, reset     : clock, synchronous active-low reset (clears count/pointers)
//   push/push_data : write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   count          : number of valid entries
//   head_data      : oldest entry, meaningful only while count != 0
module booth_result_fifo
  import booth_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic [WIDTH-1:0]              head_data
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Pointers wrap explicitly so non-power-of-two depths behave.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/booth_issue_ctrl.sv
// booth_issue_ctrl: accepts signed 8x8 operand pairs, drives an external
// Booth multiplier one operation at a time, and buffers products.
//   clk, reset            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake; in_a/in_b are the operands
//   mul_start             : one-cycle start pulse; mul_a/mul_b latched operands
//   mul_done/mul_product  : multiplier idle flag and result
//   out_valid/out_ready   : result handshake; out_product is the buffer head
//   err                   : sticky watchdog timeout
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        in_ready,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_product,
  output logic        out_valid,
  output logic [15:0] out_product,
  input  logic        out_ready,
  output logic        err
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int WD_W  = cnt_width(WDOG_LIMIT);

  state_t          state_q, state_d;
  logic            mul_start_q, mul_start_d;
  logic [7:0]      mul_a_q, mul_a_d;
  logic [7:0]      mul_b_q, mul_b_d;
  logic [WD_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic            err_q, err_d;
  logic            wdog_expire;
  logic            accept;
  logic            push, pop;
  logic [CNT_W-1:0] fifo_count;

  // Accept is gated on buffer space so a completed product always fits.
  assign in_ready    = (state_q == ST_IDLE) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;
  assign wdog_inc    = wdog_q + 1'b1;
  assign wdog_expire = (wdog_inc == WD_W'(WDOG_LIMIT));
  assign pop         = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_ISSUE;
          mul_start_d = 1'b1;
          mul_a_d     = in_a;
          mul_b_d     = in_b;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_LOW;
        wdog_d  = '0;
      end
      ST_WAIT_LOW: begin
        // Waiting for the multiplier to acknowledge start by dropping done.
        if (wdog_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_inc;
          if (!mul_done) begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        // A completion on the expiry cycle still counts as a good result.
        if (mul_done) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
    end
  end

  booth_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mul_product),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (out_product)
  );

  assign out_valid = (fifo_count != '0);
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign err       = err_q;

endmodule
